// File: rtl/hist2d_accumulate_pkg.sv
//============================================================================
// Module : hist2d_accumulate_pkg
// Brief  : Shared state encoding, out-of-range code and default sizes for
//          the 2-D histogram accumulator.
// Rev    : 1.0
//============================================================================
`default_nettype none

package hist2d_accumulate_pkg;

    localparam int DEF_COORD_W = 4;
    localparam int DEF_COUNT_W = 16;

    localparam logic [5:0] OOR_COORD = 6'd63;

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_CLEAR = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_INC   = 2'd2;
    localparam state_t ST_DUMP  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/hist2d_counter_mem.sv
//============================================================================
// Module : hist2d_counter_mem
// Brief  : Bin counter array: one combinational read port, one write port
//          that either zeroes or increments (wrap, or saturate when
//          HIST2D_ACCUMULATE_SAT_EN is defined) the addressed counter.
// Rev    : 1.0
//============================================================================
`default_nettype none

module hist2d_counter_mem
    import hist2d_accumulate_pkg::*;
#(
    parameter int ADDR_W  = 2 * DEF_COORD_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk100,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COUNT_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic               wr_clr,
    input  logic [ADDR_W-1:0]  wr_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    // Contents are not reset; the controller sweeps them to zero after reset.
    logic [COUNT_W-1:0] mem [0:DEPTH-1];
    logic [COUNT_W-1:0] cur_val;
    logic [COUNT_W-1:0] next_val;

    assign rd_data = mem[rd_addr];
    assign cur_val = mem[wr_addr];

    always_comb begin
        next_val = '0;
        if (!wr_clr) begin
`ifdef HIST2D_ACCUMULATE_SAT_EN
            next_val = (&cur_val) ? cur_val : cur_val + 1'b1;
`else
            next_val = cur_val + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk100) begin
        if (wr_en) begin
            mem[wr_addr] <= next_val;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hist2d_accumulate.sv
//============================================================================
// Module : hist2d_accumulate
// Brief  : 2-D (I/Q) histogram accumulator with zeroing sweep and
//          read-and-clear dump. Macro HIST2D_ACCUMULATE_SAT_EN selects
//          saturating counters (default: wrapping).
// Rev    : 1.0
//============================================================================
`default_nettype none

module hist2d_accumulate
    import hist2d_accumulate_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk100,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         in_i_coord,
    input  logic [5:0]         in_q_coord,
    input  logic               dump_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_i_coord,
    output logic [5:0]         out_q_coord,
    output logic [COUNT_W-1:0] out_count,
    output logic               busy,
    output logic               dump_done
);

    localparam int ADDR_W = 2 * COORD_W;
    localparam int N      = 1 << ADDR_W;
    localparam int IDX_W  = ADDR_W + 1;

    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] OOR_BEAT = IDX_W'(N);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [ADDR_W-1:0]  inc_addr;
    logic               dump_pending;
    logic [COUNT_W-1:0] oor_cnt;
    logic [COUNT_W-1:0] oor_inc;

    logic               accept;
    logic               pair_oor;
    logic               beat_take;
    logic               final_take;

    logic               mem_wr_en;
    logic               mem_wr_clr;
    logic [ADDR_W-1:0]  mem_wr_addr;
    logic [COUNT_W-1:0] mem_rd_data;

    assign accept     = in_valid && in_ready;
    assign pair_oor   = (in_i_coord == OOR_COORD) || (in_q_coord == OOR_COORD) ||
                        (|(in_i_coord >> COORD_W)) || (|(in_q_coord >> COORD_W));
    assign beat_take  = (state == ST_DUMP) && out_ready;
    assign final_take = beat_take && (idx == OOR_BEAT);

`ifdef HIST2D_ACCUMULATE_SAT_EN
    assign oor_inc = (&oor_cnt) ? oor_cnt : oor_cnt + 1'b1;
`else
    assign oor_inc = oor_cnt + 1'b1;
`endif

    hist2d_counter_mem #(
        .ADDR_W  (ADDR_W),
        .COUNT_W (COUNT_W)
    ) u_mem (
        .clk100  (clk100),
        .rd_addr (idx[ADDR_W-1:0]),
        .rd_data (mem_rd_data),
        .wr_en   (mem_wr_en),
        .wr_clr  (mem_wr_clr),
        .wr_addr (mem_wr_addr)
    );

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (idx == LAST_BIN) state_nxt = ST_ACCUM;
            ST_ACCUM: begin
                if (clear)                    state_nxt = ST_CLEAR;
                else if (dump_pending)        state_nxt = ST_DUMP;
                else if (accept && !pair_oor) state_nxt = ST_INC;
            end
            ST_INC:   state_nxt = ST_ACCUM;
            ST_DUMP:  if (final_take) state_nxt = ST_ACCUM;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        busy        = 1'b1;
        out_valid   = 1'b0;
        out_i_coord = '0;
        out_q_coord = '0;
        out_count   = '0;
        mem_wr_en   = 1'b0;
        mem_wr_clr  = 1'b0;
        mem_wr_addr = idx[ADDR_W-1:0];
        case (state)
            ST_CLEAR: begin
                mem_wr_en  = 1'b1;
                mem_wr_clr = 1'b1;
            end
            ST_ACCUM: begin
                busy     = 1'b0;
                in_ready = !dump_pending;
            end
            ST_INC: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = inc_addr;
            end
            ST_DUMP: begin
                out_valid = 1'b1;
                if (idx == OOR_BEAT) begin
                    out_i_coord = OOR_COORD;
                    out_q_coord = OOR_COORD;
                    out_count   = oor_cnt;
                end else begin
                    // Read-and-clear: the bin is zeroed on the edge that accepts it.
                    out_i_coord = 6'(idx[COORD_W-1:0]);
                    out_q_coord = 6'(idx[ADDR_W-1:COORD_W]);
                    out_count   = mem_rd_data;
                    mem_wr_en   = out_ready;
                    mem_wr_clr  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            inc_addr     <= '0;
            dump_pending <= 1'b0;
            oor_cnt      <= '0;
            dump_done    <= 1'b0;
        end else begin
            dump_done <= final_take;

            if (state_nxt != state) begin
                idx <= '0;
            end else if ((state == ST_CLEAR) || beat_take) begin
                idx <= idx + 1'b1;
            end

            if (accept) begin
                inc_addr <= {in_q_coord[COORD_W-1:0], in_i_coord[COORD_W-1:0]};
            end

            if ((state == ST_ACCUM) && (state_nxt == ST_DUMP)) begin
                dump_pending <= 1'b0;
            end else if (dump_req && (state != ST_DUMP)) begin
                dump_pending <= 1'b1;
            end

            if (((state == ST_ACCUM) && clear) || final_take) begin
                oor_cnt <= '0;
            end else if (accept && pair_oor) begin
                oor_cnt <= oor_inc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hist2d_accumulate.sv
//============================================================================
// Module : tb_hist2d_accumulate
// Brief  : Directed self-checking bench with a beat scoreboard.
// Rev    : 1.0
//============================================================================
`default_nettype none

module tb_hist2d_accumulate;

    logic        clk100;
    logic        rst_n;
    logic        clear, in_valid, in_ready, dump_req;
    logic [5:0]  in_i_coord, in_q_coord;
    logic        out_valid, out_ready, busy, dump_done;
    logic [5:0]  out_i_coord, out_q_coord;
    logic [15:0] out_count;

    logic        s_clear, s_in_valid, s_in_ready, s_dump_req;
    logic [5:0]  s_in_i_coord, s_in_q_coord;
    logic        s_out_valid, s_out_ready, s_busy, s_dump_done;
    logic [5:0]  s_out_i_coord, s_out_q_coord;
    logic [1:0]  s_out_count;

    int errors = 0;
    int checks = 0;
    int model [0:255];
    int model_oor;
    logic [27:0] sb [$];

    hist2d_accumulate #(.COORD_W(4), .COUNT_W(16)) dut (
        .clk100(clk100), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_i_coord(in_i_coord), .in_q_coord(in_q_coord),
        .dump_req(dump_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_i_coord(out_i_coord), .out_q_coord(out_q_coord),
        .out_count(out_count), .busy(busy), .dump_done(dump_done)
    );

    hist2d_accumulate #(.COORD_W(4), .COUNT_W(2)) dut_small (
        .clk100(clk100), .rst_n(rst_n), .clear(s_clear),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_i_coord(s_in_i_coord), .in_q_coord(s_in_q_coord),
        .dump_req(s_dump_req), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_i_coord(s_out_i_coord), .out_q_coord(s_out_q_coord),
        .out_count(s_out_count), .busy(s_busy), .dump_done(s_dump_done)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic zero_model();
        for (int b = 0; b < 256; b++) model[b] = 0;
        model_oor = 0;
    endtask

    // Expected beats for one dump, in bin order, then the out-of-range beat.
    task automatic push_expect();
        for (int b = 0; b < 256; b++)
            sb.push_back({6'(b / 16), 6'(b % 16), 16'(model[b])});
        sb.push_back({6'd63, 6'd63, 16'(model_oor)});
        zero_model();
    endtask

    task automatic wait_sweep(input string tag);
        int cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clk100);
        end
        chk(tag, cnt, 256);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    endtask

    task automatic send(input logic [5:0] i, input logic [5:0] q);
        int n = 0;
        in_valid   = 1'b1;
        in_i_coord = i;
        in_q_coord = q;
        while (!in_ready && n < 100) begin
            @(negedge clk100);
            n++;
        end
        if (n >= 100) chk("send_timeout", n, 0);
        @(negedge clk100);
        in_valid = 1'b0;
        if (i < 16 && q < 16) model[q * 16 + i]++;
        else                  model_oor++;
    endtask

    task automatic do_dump(input bit issue, input bit toggle, input int abort_at);
        int beats = 0, done_cnt = 0, cyc = 0;
        bit have_prev = 0;
        logic [27:0] cur, prev, exp;
        if (issue) begin
            push_expect();
            dump_req = 1'b1;
            @(negedge clk100);
            dump_req = 1'b0;
        end
        out_ready = 1'b1;
        while (beats < 257 && cyc < 3000) begin
            @(negedge clk100);
            cyc++;
            if (dump_done) done_cnt++;
            if (toggle) out_ready = cyc[0];
            if (out_valid) begin
                if (abort_at >= 0 && beats == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_out_valid", {31'd0, out_valid}, 0);
                    chk("abort_busy", {31'd0, busy}, 1);
                    chk("abort_in_ready", {31'd0, in_ready}, 0);
                    sb.delete();
                    zero_model();
                    return;
                end
                cur = {out_q_coord, out_i_coord, out_count};
                if (have_prev) chk("stall_stable", cur, prev);
                if (out_ready) begin
                    exp = (sb.size() > 0) ? sb.pop_front() : 28'hfffffff;
                    chk($sformatf("beat%0d", beats), cur, exp);
                    beats++;
                    have_prev = 0;
                end else begin
                    prev = cur;
                    have_prev = 1;
                end
            end
        end
        chk("dump_beats", beats, 257);
        @(negedge clk100);
        if (dump_done) done_cnt++;
        @(negedge clk100);
        if (dump_done) done_cnt++;
        chk("dump_done_pulses", done_cnt, 1);
        chk("post_dump_out_valid", {31'd0, out_valid}, 0);
        chk("post_dump_in_ready", {31'd0, in_ready}, 1);
    endtask

    initial begin
        int n;
        logic [1:0] sat_exp;
        rst_n = 1'b0;
        clear = 0; in_valid = 0; dump_req = 0; out_ready = 0;
        in_i_coord = 0; in_q_coord = 0;
        s_clear = 0; s_in_valid = 0; s_dump_req = 0; s_out_ready = 0;
        s_in_i_coord = 0; s_in_q_coord = 0;
        zero_model();

        repeat (3) @(negedge clk100);
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_dump_done", {31'd0, dump_done}, 0);
        chk("rst_payload", {4'd0, out_q_coord, out_i_coord, out_count}, 0);
        rst_n = 1'b1;
        wait_sweep("reset_sweep");

        // Narrow counters: five hits on bin (0,0).
        for (int k = 0; k < 5; k++) begin
            s_in_valid = 1'b1;
            n = 0;
            while (!s_in_ready && n < 100) begin @(negedge clk100); n++; end
            @(negedge clk100);
            s_in_valid = 1'b0;
        end
        @(negedge clk100);
        s_dump_req = 1'b1;
        @(negedge clk100);
        s_dump_req = 1'b0;
        s_out_ready = 1'b1;
        n = 0;
        while (!s_out_valid && n < 100) begin @(negedge clk100); n++; end
`ifdef HIST2D_ACCUMULATE_SAT_EN
        sat_exp = 2'd3;
`else
        sat_exp = 2'd1;
`endif
        chk("narrow_bin0", {18'd0, s_out_valid, s_out_q_coord, s_out_i_coord, s_out_count},
            {18'd0, 1'b1, 6'd0, 6'd0, sat_exp});

        // Back-to-back same-bin hits.
        repeat (3) send(6'd3, 6'd5);
        do_dump(1, 0, -1);

        // Out-of-range pairs mixed with one in-range pair.
        send(6'd63, 6'd2);
        send(6'd16, 6'd0);
        send(6'd1, 6'd1);
        do_dump(1, 0, -1);

        // Stalled dump, then confirm read-and-clear.
        send(6'd7, 6'd9);
        send(6'd0, 6'd0);
        send(6'd15, 6'd15);
        do_dump(1, 1, -1);
        do_dump(1, 0, -1);

        // Clear discards bins and the out-of-range count.
        send(6'd2, 6'd2);
        send(6'd63, 6'd63);
        clear = 1'b1;
        @(negedge clk100);
        clear = 1'b0;
        zero_model();
        wait_sweep("clear_sweep");
        do_dump(1, 0, -1);

        // Clear together with dump_req: sweep first, then dump.
        send(6'd4, 6'd4);
        send(6'd40, 6'd1);
        zero_model();
        push_expect();
        clear = 1'b1;
        dump_req = 1'b1;
        @(negedge clk100);
        clear = 1'b0;
        dump_req = 1'b0;
        chk("clear_dump_busy", {31'd0, busy}, 1);
        do_dump(0, 0, -1);

        // Reset during a dump.
        send(6'd5, 6'd5);
        send(6'd63, 6'd0);
        do_dump(1, 0, 10);
        @(negedge clk100);
        rst_n = 1'b1;
        wait_sweep("post_reset_sweep");
        do_dump(1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
